// File: rtl/mmio_responder.sv
// mmio_responder: memory-mapped I/O window (32 bytes at BASE_ADDR) beside the
// data RAM. Holds LED / seven-segment registers, synchronizes switches,
// debounces buttons into sticky press events. The free-running timer with
// compare flag is built only when MMIO_TIMER_EN is defined.
module mmio_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_FC00,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_wen_i,
  input  logic [31:0] mem_adr_i,
  input  logic [31:0] mem_dat_i,
  output logic [31:0] mem_dat_o,
  output logic        hit_o,
  input  logic [15:0] sw_i,
  input  logic [4:0]  btn_i,
  output logic [15:0] led_o,
  output logic [31:0] seg_val_o,
  output logic        timer_irq_o
);

  localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic        hit;
  logic [2:0]  off;
  logic        wr;
  logic        unused_adr;

  logic [15:0] led_q, led_d;
  logic [31:0] seg_q, seg_d;
  logic [15:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [4:0]  btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic [4:0]  btn_stb_q, btn_stb_d;
  logic [19:0] cnt_q [5];
  logic [19:0] cnt_d [5];
  logic [4:0]  evt_q, evt_d;
  logic [31:0] rd_dat;

  // Byte lanes are not used: the window is word-addressed.
  assign hit        = (mem_adr_i[31:5] == BASE_ADDR[31:5]);
  assign off        = mem_adr_i[4:2];
  assign wr         = mem_wen_i & hit;
  assign unused_adr = ^mem_adr_i[1:0];

  // Register writes, input synchronizers, debounce counters and sticky events.
  always_comb begin
    led_d = led_q;
    if (wr && off == 3'd0) led_d = mem_dat_i[15:0];
    seg_d = seg_q;
    if (wr && off == 3'd4) seg_d = mem_dat_i;

    sw_s1_d  = sw_i;
    sw_s2_d  = sw_s1_q;
    btn_s1_d = btn_i;
    btn_s2_d = btn_s1_q;

    // A new level must persist DEBOUNCE_CYCLES synced cycles to be accepted;
    // any return to the stable level restarts the count.
    btn_stb_d = btn_stb_q;
    for (int i = 0; i < 5; i++) begin
      cnt_d[i] = '0;
      if (btn_s2_q[i] != btn_stb_q[i]) begin
        if (cnt_q[i] == DB_LAST) btn_stb_d[i] = btn_s2_q[i];
        else                     cnt_d[i]     = cnt_q[i] + 20'd1;
      end
    end

    // Clear first, then OR in new rising edges so a simultaneous press wins.
    evt_d = evt_q;
    if (wr && off == 3'd3) evt_d = evt_q & ~mem_dat_i[4:0];
    evt_d = evt_d | (btn_stb_d & ~btn_stb_q);
  end

  // Core state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q     <= '0;
      seg_q     <= '0;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      btn_s1_q  <= '0;
      btn_s2_q  <= '0;
      btn_stb_q <= '0;
      evt_q     <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      led_q     <= led_d;
      seg_q     <= seg_d;
      sw_s1_q   <= sw_s1_d;
      sw_s2_q   <= sw_s2_d;
      btn_s1_q  <= btn_s1_d;
      btn_s2_q  <= btn_s2_d;
      btn_stb_q <= btn_stb_d;
      evt_q     <= evt_d;
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] timer_q, timer_d;
  logic [31:0] cmp_q, cmp_d;
  logic        flag_q, flag_d;

  // Timer counts every cycle; a store overrides that cycle's increment.
  // Match compares the current register values and beats a same-edge clear.
  always_comb begin
    timer_d = timer_q + 32'd1;
    if (wr && off == 3'd5) timer_d = mem_dat_i;
    cmp_d = cmp_q;
    if (wr && off == 3'd6) cmp_d = mem_dat_i;
    flag_d = flag_q;
    if (wr && off == 3'd7 && mem_dat_i[0]) flag_d = 1'b0;
    if (timer_q == cmp_q) flag_d = 1'b1;
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      cmp_q   <= 32'hFFFF_FFFF;
      flag_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      cmp_q   <= cmp_d;
      flag_q  <= flag_d;
    end
  end

  assign timer_irq_o = flag_q;
`else
  assign timer_irq_o = 1'b0;
`endif

  // Load data mux; zero outside the window and for unimplemented offsets.
  always_comb begin
    rd_dat = '0;
    case (off)
      3'd0: rd_dat = {16'h0, led_q};
      3'd1: rd_dat = {16'h0, sw_s2_q};
      3'd2: rd_dat = {27'h0, btn_stb_q};
      3'd3: rd_dat = {27'h0, evt_q};
      3'd4: rd_dat = seg_q;
`ifdef MMIO_TIMER_EN
      3'd5: rd_dat = timer_q;
      3'd6: rd_dat = cmp_q;
      3'd7: rd_dat = {31'h0, flag_q};
`endif
      default: rd_dat = '0;
    endcase
  end

  assign hit_o     = hit;
  assign mem_dat_o = hit ? rd_dat : 32'h0;
  assign led_o     = led_q;
  assign seg_val_o = seg_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Testbench for mmio_responder with DEBOUNCE_CYCLES=4: register table,
// switch sync, debounce/event corners, optional timer, mid-run reset.
module tb_mmio_responder;

  localparam logic [31:0] B = 32'hFFFF_FC00;

  logic        clk;
  logic        rst_n;
  logic        mem_wen_i;
  logic [31:0] mem_adr_i;
  logic [31:0] mem_dat_i;
  logic [31:0] mem_dat_o;
  logic        hit_o;
  logic [15:0] sw_i;
  logic [4:0]  btn_i;
  logic [15:0] led_o;
  logic [31:0] seg_val_o;
  logic        timer_irq_o;

  mmio_responder #(.BASE_ADDR(B), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_wen_i(mem_wen_i), .mem_adr_i(mem_adr_i), .mem_dat_i(mem_dat_i),
    .mem_dat_o(mem_dat_o), .hit_o(hit_o),
    .sw_i(sw_i), .btn_i(btn_i),
    .led_o(led_o), .seg_val_o(seg_val_o), .timer_irq_o(timer_irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        hit;
    logic [31:0] rd;
  } vec_t;

  vec_t        vecs [13];
  logic [31:0] exp_q [$];
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a load, queue its expected data, compare once it settles.
  task automatic load_chk(input string nm, input logic [31:0] adr, input logic [31:0] exp);
    mem_wen_i = 1'b0;
    mem_adr_i = adr;
    exp_q.push_back(exp);
    #1;
    chk(nm, mem_dat_o, exp_q.pop_front());
  endtask

  task automatic store(input logic [31:0] adr, input logic [31:0] dat);
    mem_wen_i = 1'b1;
    mem_adr_i = adr;
    mem_dat_i = dat;
    tick();
    mem_wen_i = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, B + 32'h00, 32'h0,         1'b1, 32'h0};
    vecs[1]  = '{1'b1, B + 32'h00, 32'h0000_A5A5, 1'b1, 32'h0};
    vecs[2]  = '{1'b1, B + 32'h10, 32'h1234_5678, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, B + 32'h00, 32'h0,         1'b1, 32'h0000_A5A5};
    vecs[4]  = '{1'b0, B + 32'h10, 32'h0,         1'b1, 32'h1234_5678};
    vecs[5]  = '{1'b0, 32'h0,      32'h0,         1'b0, 32'h0};
    vecs[6]  = '{1'b1, B + 32'h04, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, B + 32'h04, 32'h0,         1'b1, 32'h0};
    vecs[8]  = '{1'b1, 32'h0,      32'h0000_DEAD, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, B + 32'h03, 32'h0,         1'b1, 32'h0000_A5A5};
    vecs[10] = '{1'b0, B + 32'h20, 32'h0,         1'b0, 32'h0};
    vecs[11] = '{1'b1, B + 32'h00, 32'hFFFF_1234, 1'b1, 32'h0000_A5A5};
    vecs[12] = '{1'b0, B + 32'h00, 32'h0,         1'b1, 32'h0000_1234};

    rst_n = 1'b0; mem_wen_i = 1'b0; mem_adr_i = '0; mem_dat_i = '0;
    sw_i = '0; btn_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_led", {16'h0, led_o}, 32'h0);
    chk("rst_seg", seg_val_o, 32'h0);
    chk("rst_irq", {31'h0, timer_irq_o}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Register map table: read data is the pre-edge state.
    for (int i = 0; i < 13; i++) begin
      mem_wen_i = vecs[i].wen;
      mem_adr_i = vecs[i].adr;
      mem_dat_i = vecs[i].dat;
      exp_q.push_back(vecs[i].rd);
      #1;
      chk($sformatf("vec%0d_hit", i), {31'h0, hit_o}, {31'h0, vecs[i].hit});
      chk($sformatf("vec%0d_rd", i), mem_dat_o, exp_q.pop_front());
      tick();
      mem_wen_i = 1'b0;
    end
    chk("led_out", {16'h0, led_o}, 32'h0000_1234);
    chk("seg_out", seg_val_o, 32'h1234_5678);

    // Switch synchronizer: two edges.
    sw_i = 16'hBEEF;
    load_chk("sw_0edge", B + 32'h04, 32'h0);
    tick();
    load_chk("sw_1edge", B + 32'h04, 32'h0);
    tick();
    load_chk("sw_2edge", B + 32'h04, 32'h0000_BEEF);

    // Glitch: three synced-high cycles never reach acceptance.
    btn_i = 5'b00100;
    repeat (3) tick();
    btn_i = 5'b00000;
    repeat (4) tick();
    load_chk("glitch_btn", B + 32'h08, 32'h0);
    load_chk("glitch_evt", B + 32'h0C, 32'h0);

    // Clean press: accepted on edge 2 + 4.
    btn_i = 5'b00100;
    repeat (5) tick();
    load_chk("press5_btn", B + 32'h08, 32'h0);
    tick();
    load_chk("press6_btn", B + 32'h08, 32'h4);
    load_chk("press6_evt", B + 32'h0C, 32'h4);
    store(B + 32'h0C, 32'h4);
    load_chk("w1c_evt", B + 32'h0C, 32'h0);
    load_chk("w1c_btn", B + 32'h08, 32'h4);

    // Release sets nothing; re-press sets the event again.
    btn_i = 5'b00000;
    repeat (8) tick();
    load_chk("rel_btn", B + 32'h08, 32'h0);
    load_chk("rel_evt", B + 32'h0C, 32'h0);
    btn_i = 5'b00100;
    repeat (6) tick();
    load_chk("repress_evt", B + 32'h0C, 32'h4);

    // W1C on the very edge a new press is accepted: set wins.
    btn_i = 5'b00000;
    repeat (8) tick();
    load_chk("rel2_evt", B + 32'h0C, 32'h4);
    btn_i = 5'b00100;
    repeat (5) tick();
    store(B + 32'h0C, 32'h4);
    load_chk("setwin_evt", B + 32'h0C, 32'h4);
    load_chk("setwin_btn", B + 32'h08, 32'h4);

    // Mid-debounce reset with event pending and LED/SEG set.
    store(B + 32'h00, 32'h0000_00FF);
    store(B + 32'h10, 32'hCAFE_F00D);
    btn_i = 5'b00101;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("rst2_led", {16'h0, led_o}, 32'h0);
    chk("rst2_seg", seg_val_o, 32'h0);
    chk("rst2_irq", {31'h0, timer_irq_o}, 32'h0);
    load_chk("rst2_rd_led", B + 32'h00, 32'h0);
    load_chk("rst2_rd_sw",  B + 32'h04, 32'h0);
    load_chk("rst2_rd_btn", B + 32'h08, 32'h0);
    load_chk("rst2_rd_evt", B + 32'h0C, 32'h0);
    load_chk("rst2_rd_seg", B + 32'h10, 32'h0);
`ifdef MMIO_TIMER_EN
    load_chk("rst2_rd_tmr", B + 32'h14, 32'h0);
    load_chk("rst2_rd_cmp", B + 32'h18, 32'hFFFF_FFFF);
`else
    load_chk("rst2_rd_tmr", B + 32'h14, 32'h0);
    load_chk("rst2_rd_cmp", B + 32'h18, 32'h0);
`endif
    btn_i = 5'b00000;
    sw_i  = 16'h0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    load_chk("post_rst_btn", B + 32'h08, 32'h0);
    load_chk("post_rst_evt", B + 32'h0C, 32'h0);

`ifdef MMIO_TIMER_EN
    // Timer wrap, compare match and flag clear.
    store(B + 32'h14, 32'hFFFF_FFFE);
    store(B + 32'h18, 32'h0000_0001);
    load_chk("tmr_ffff", B + 32'h14, 32'hFFFF_FFFF);
    tick();
    load_chk("tmr_wrap", B + 32'h14, 32'h0);
    tick();
    load_chk("tmr_one", B + 32'h14, 32'h1);
    chk("irq_before", {31'h0, timer_irq_o}, 32'h0);
    tick();
    chk("irq_set", {31'h0, timer_irq_o}, 32'h1);
    load_chk("stat_set", B + 32'h1C, 32'h1);
    store(B + 32'h1C, 32'h1);
    chk("irq_clr", {31'h0, timer_irq_o}, 32'h0);
`else
    // Timer absent: window tail reads zero and ignores writes.
    store(B + 32'h14, 32'h0000_0055);
    store(B + 32'h18, 32'h0000_0000);
    repeat (2) tick();
    load_chk("notmr_14", B + 32'h14, 32'h0);
    load_chk("notmr_18", B + 32'h18, 32'h0);
    load_chk("notmr_1c", B + 32'h1C, 32'h0);
    chk("notmr_irq", {31'h0, timer_irq_o}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
